// File: rtl/axi4_full_slave_mem_if.sv
// rtl/axi4_full_slave_mem_if.sv - AXI4 write/read burst channel bundle for axi4_full_slave_mem
interface axi4_full_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_full_slave_mem.sv
// rtl/axi4_full_slave_mem.sv - AXI4 INCR burst slave over dual-port word memory
// Optional LFSR-driven backpressure when AXI_SLAVE_MEM_STALL_EN is defined.
module axi4_full_slave_mem #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_DEPTH        = 1024,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_BASE_ADDR = '0
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  axi4_full_slave_mem_if.slave s_axi
);
  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(C_MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  function automatic idx_t addr_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [C_S_AXI_ADDR_WIDTH-1:0] off;
    off = addr - C_S_AXI_BASE_ADDR;
    return off[ADDR_LSB +: IDX_W];
  endfunction

  // Out of range whenever any offset bit above the word-index field is set.
  function automatic logic addr_oor(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [C_S_AXI_ADDR_WIDTH-1:0] off;
    off = addr - C_S_AXI_BASE_ADDR;
    return (off >> (ADDR_LSB + IDX_W)) != '0;
  endfunction

  logic ready_ok;
  logic fetch_ok;

`ifdef AXI_SLAVE_MEM_STALL_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) lfsr <= 16'hACE1;
    else                lfsr <= lfsr_next;
  end

  // READY outputs are registered, so gate them with the value the LFSR holds next cycle.
  assign ready_ok = lfsr_next[0];
  assign fetch_ok = lfsr[1];
`else
  assign ready_ok = 1'b1;
  assign fetch_ok = 1'b1;
`endif

  wstate_t    wstate;
  idx_t       w_idx;
  logic [7:0] w_len;
  logic [7:0] w_cnt;
  logic       w_oor;
  logic       w_err;
  logic       w_beat;

  assign w_beat = (wstate == W_DATA) && s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate              <= W_IDLE;
      w_idx               <= '0;
      w_len               <= '0;
      w_cnt               <= '0;
      w_oor               <= 1'b0;
      w_err               <= 1'b0;
      s_axi.S_AXI_AWREADY <= 1'b0;
      s_axi.S_AXI_WREADY  <= 1'b0;
      s_axi.S_AXI_BVALID  <= 1'b0;
      s_axi.S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axi.S_AXI_AWREADY <= ready_ok;
          if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY) begin
            w_idx               <= addr_idx(s_axi.S_AXI_AWADDR);
            w_oor               <= addr_oor(s_axi.S_AXI_AWADDR);
            w_len               <= s_axi.S_AXI_AWLEN;
            w_cnt               <= '0;
            w_err               <= 1'b0;
            s_axi.S_AXI_AWREADY <= 1'b0;
            s_axi.S_AXI_WREADY  <= ready_ok;
            wstate              <= W_DATA;
          end
        end
        W_DATA: begin
          s_axi.S_AXI_WREADY <= ready_ok;
          if (w_beat) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              s_axi.S_AXI_WREADY <= 1'b0;
              s_axi.S_AXI_BVALID <= 1'b1;
              s_axi.S_AXI_BRESP  <= (w_oor || w_err || !s_axi.S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
              wstate             <= W_RESP;
            end else if (s_axi.S_AXI_WLAST) begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            s_axi.S_AXI_BVALID  <= 1'b0;
            s_axi.S_AXI_BRESP   <= RESP_OKAY;
            s_axi.S_AXI_AWREADY <= ready_ok;
            wstate              <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Memory has no reset; contents survive S_AXI_ARESETN.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_beat && !w_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  rstate_t    rstate;
  idx_t       r_idx;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic       r_oor;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate              <= R_IDLE;
      r_idx               <= '0;
      r_len               <= '0;
      r_cnt               <= '0;
      r_oor               <= 1'b0;
      s_axi.S_AXI_ARREADY <= 1'b0;
      s_axi.S_AXI_RVALID  <= 1'b0;
      s_axi.S_AXI_RDATA   <= '0;
      s_axi.S_AXI_RRESP   <= RESP_OKAY;
      s_axi.S_AXI_RLAST   <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axi.S_AXI_ARREADY <= ready_ok;
          if (s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY) begin
            r_idx               <= addr_idx(s_axi.S_AXI_ARADDR);
            r_oor               <= addr_oor(s_axi.S_AXI_ARADDR);
            r_len               <= s_axi.S_AXI_ARLEN;
            r_cnt               <= '0;
            s_axi.S_AXI_ARREADY <= 1'b0;
            rstate              <= R_FETCH;
          end
        end
        R_FETCH: begin
          // Read sees the pre-write value when the write port hits the same word this cycle.
          if (fetch_ok) begin
            s_axi.S_AXI_RDATA  <= r_oor ? '0 : mem[r_idx];
            s_axi.S_AXI_RRESP  <= r_oor ? RESP_SLVERR : RESP_OKAY;
            s_axi.S_AXI_RLAST  <= (r_cnt == r_len);
            s_axi.S_AXI_RVALID <= 1'b1;
            rstate             <= R_VALID;
          end
        end
        R_VALID: begin
          if (s_axi.S_AXI_RREADY) begin
            s_axi.S_AXI_RVALID <= 1'b0;
            s_axi.S_AXI_RLAST  <= 1'b0;
            if (s_axi.S_AXI_RLAST) begin
              s_axi.S_AXI_ARREADY <= ready_ok;
              rstate              <= R_IDLE;
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_cnt  <= r_cnt + 8'd1;
              rstate <= R_FETCH;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// tb/tb_axi4_full_slave_mem.sv - randomized scoreboard bench for axi4_full_slave_mem
module tb_axi4_full_slave_mem;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_full_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_full_slave_mem #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH(DEPTH),
    .C_S_AXI_BASE_ADDR(BASE)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  int          first_lat;
  int          b_wait;
  logic [1:0]  got_bresp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_write(input logic [31:0] addr, input int len);
    logic [31:0] idx;
    idx = (addr - BASE) >> 2;
    if (idx < DEPTH) begin
      for (int b = 0; b <= len; b++) begin
        for (int k = 0; k < 4; k++) begin
          if (wq_strb[b][k]) ref_mem[(idx + b) % DEPTH][k*8 +: 8] = wq_data[b][k*8 +: 8];
        end
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int early);
    int t;
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_AWLEN = 8'(len);
    bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.S_AXI_AWREADY && t < 200);
    if (!bus.S_AXI_AWREADY) begin checks++; errors++; $display("FAIL aw_handshake: AWREADY=%0d, required 1 within 200 cycles", bus.S_AXI_AWREADY); end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.S_AXI_WDATA = wq_data[b];
      bus.S_AXI_WSTRB = wq_strb[b];
      bus.S_AXI_WLAST = (early >= 0) ? (b == early) : (b == len);
      bus.S_AXI_WVALID = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.S_AXI_WREADY && t < 200);
      if (!bus.S_AXI_WREADY) begin checks++; errors++; $display("FAIL w_handshake beat %0d: WREADY=%0d, required 1", b, bus.S_AXI_WREADY); end
      @(posedge clk); #1;
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.S_AXI_BVALID && t < 200);
    b_wait = t;
    got_bresp = bus.S_AXI_BRESP;
    if (!bus.S_AXI_BVALID) begin checks++; errors++; $display("FAIL b_handshake: BVALID=%0d, required 1", bus.S_AXI_BVALID); end
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    model_write(addr, len);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int hold);
    int t;
    logic [31:0] hd;
    logic hl;
    rq_data.delete(); rq_resp.delete(); rq_last.delete();
    @(posedge clk); #1;
    bus.S_AXI_ARADDR = addr;
    bus.S_AXI_ARLEN = 8'(len);
    bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.S_AXI_ARREADY && t < 200);
    if (!bus.S_AXI_ARREADY) begin checks++; errors++; $display("FAIL ar_handshake: ARREADY=%0d, required 1", bus.S_AXI_ARREADY); end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = (hold != 0);
    for (int b = 0; b <= len; b++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.S_AXI_RVALID && t < 200);
      if (b == 0) first_lat = t;
      if (!bus.S_AXI_RVALID) begin checks++; errors++; $display("FAIL r_handshake beat %0d: RVALID=%0d, required 1", b, bus.S_AXI_RVALID); end
      rq_data.push_back(bus.S_AXI_RDATA);
      rq_resp.push_back(bus.S_AXI_RRESP);
      rq_last.push_back(bus.S_AXI_RLAST);
      if (b == hold) begin
        hd = bus.S_AXI_RDATA;
        hl = bus.S_AXI_RLAST;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== hd || bus.S_AXI_RLAST !== hl) begin
            errors++;
            $display("FAIL r_hold: RVALID=%0d RDATA=%h RLAST=%0d, required 1 %h %0d", bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RLAST, hd, hl);
          end
        end
        bus.S_AXI_RREADY = 1'b1;
      end
      @(posedge clk); #1;
      bus.S_AXI_RREADY = (b + 1 != hold);
    end
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic check_read(input logic [31:0] addr, input int len, input int hold, input string name);
    logic [31:0] idx;
    logic oor;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    do_read(addr, len, hold);
    idx = (addr - BASE) >> 2;
    oor = (idx >= DEPTH);
    checks++;
    if (rq_data.size() != len + 1) begin
      errors++;
      $display("FAIL %s beats: got %0d, required %0d", name, rq_data.size(), len + 1);
    end else begin
      for (int b = 0; b <= len; b++) begin
        exp_d = oor ? 32'h0 : ref_mem[(idx + b) % DEPTH];
        exp_r = oor ? 2'b10 : 2'b00;
        checks++;
        if (rq_data[b] !== exp_d || rq_resp[b] !== exp_r || rq_last[b] !== (b == len)) begin
          errors++;
          $display("FAIL %s beat %0d: got data=%h resp=%0d last=%0d, required data=%h resp=%0d last=%0d",
                   name, b, rq_data[b], rq_resp[b], rq_last[b], exp_d, exp_r, (b == len));
        end
      end
    end
  endtask

  task automatic fill_wq(input int n, input logic full_strb);
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < n; i++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RLAST} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: AWR/WR/ARR/BV/RV/RL=%b, required 000000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RLAST});
    end
    checks++;
    if (bus.S_AXI_BRESP !== 2'b00 || bus.S_AXI_RRESP !== 2'b00 || bus.S_AXI_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: BRESP=%0d RRESP=%0d RDATA=%h, required 0 0 0", bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`ifndef AXI_SLAVE_MEM_STALL_EN
    checks++;
    if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_ARREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: AWREADY=%0d ARREADY=%0d, required 1 1", bus.S_AXI_AWREADY, bus.S_AXI_ARREADY);
    end
`endif
  endtask

  task automatic test_fill_max_burst();
    for (int k = 0; k < DEPTH / 256; k++) begin
      fill_wq(256, 1'b1);
      do_write(32'(k * 1024), 255, -1);
      checks++;
      if (got_bresp !== 2'b00) begin errors++; $display("FAIL fill_bresp %0d: got %0d, required 0", k, got_bresp); end
    end
    check_read(32'h0, 255, -1, "fill_read");
  endtask

  task automatic test_basic();
    wq_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h0, 3, -1);
    checks++;
    if (got_bresp !== 2'b00 || b_wait !== 1) begin
      errors++;
      $display("FAIL basic_bresp: got resp=%0d after %0d cycles, required 0 after 1", got_bresp, b_wait);
    end
    check_read(32'h0, 3, -1, "basic_read");
    checks++;
    if (rq_data.size() != 4 || rq_data[0] !== 32'h11 || rq_data[3] !== 32'h44) begin
      errors++;
      $display("FAIL basic_const: got first=%h last=%h, required 11 44", rq_data[0], rq_data[3]);
    end
`ifndef AXI_SLAVE_MEM_STALL_EN
    checks++;
    if (first_lat !== 2) begin errors++; $display("FAIL read_latency: got %0d, required 2", first_lat); end
`endif
  endtask

  task automatic test_strobe();
    wq_data = '{32'h11111111}; wq_strb = '{4'hF};
    do_write(32'h14, 0, -1);
    wq_data = '{32'hAABBCCDD}; wq_strb = '{4'b0101};
    do_write(32'h14, 0, -1);
    check_read(32'h14, 0, -1, "strobe_read");
    checks++;
    if (rq_data[0] !== 32'h11BB11DD) begin errors++; $display("FAIL strobe_const: got %h, required 11bb11dd", rq_data[0]); end
  endtask

  task automatic test_wrap();
    fill_wq(4, 1'b1);
    do_write(32'((DEPTH - 2) * 4), 3, -1);
    checks++;
    if (got_bresp !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %0d, required 0", got_bresp); end
    check_read(32'h0, 1, -1, "wrap_low");
    checks++;
    if (rq_data[0] !== wq_data[2] || rq_data[1] !== wq_data[3]) begin
      errors++;
      $display("FAIL wrap_const: got %h %h, required %h %h", rq_data[0], rq_data[1], wq_data[2], wq_data[3]);
    end
    check_read(32'((DEPTH - 2) * 4), 3, -1, "wrap_read");
  endtask

  task automatic test_out_of_range();
    check_read(32'(DEPTH * 4), 1, -1, "oor_read");
    checks++;
    if (rq_data[1] !== 32'h0 || rq_resp[1] !== 2'b10) begin
      errors++;
      $display("FAIL oor_const: got data=%h resp=%0d, required 0 2", rq_data[1], rq_resp[1]);
    end
    fill_wq(2, 1'b1);
    do_write(32'(DEPTH * 4), 1, -1);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL oor_bresp: got %0d, required 2", got_bresp); end
    check_read(32'h0, 1, -1, "oor_unchanged");
  endtask

  task automatic test_wlast_early_and_hold();
    fill_wq(4, 1'b1);
    do_write(32'h40, 3, 1);
    checks++;
    if (got_bresp !== 2'b10) begin errors++; $display("FAIL wlast_bresp: got %0d, required 2", got_bresp); end
    check_read(32'h40, 3, 1, "hold_read");
  endtask

  task automatic test_reset_mid_burst();
    int t;
    @(posedge clk); #1;
    bus.S_AXI_ARADDR = 32'h0;
    bus.S_AXI_ARLEN = 8'd7;
    bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.S_AXI_ARREADY && t < 200);
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    for (int b = 0; b < 2; b++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.S_AXI_RVALID && t < 200);
      @(posedge clk); #1;
    end
    bus.S_AXI_RREADY = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.S_AXI_RVALID && t < 200);
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1) begin errors++; $display("FAIL midrst_beat2: RVALID=%0d, required 1", bus.S_AXI_RVALID); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: RVALID=%0d RLAST=%0d, required 0 0", bus.S_AXI_RVALID, bus.S_AXI_RLAST);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.S_AXI_RVALID !== 1'b0) begin errors++; $display("FAIL midrst_no_resp: RVALID=%0d, required 0", bus.S_AXI_RVALID); end
    end
`ifndef AXI_SLAVE_MEM_STALL_EN
    checks++;
    if (bus.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL midrst_idle: ARREADY=%0d, required 1", bus.S_AXI_ARREADY); end
`endif
    check_read(32'h0, 7, -1, "midrst_after");
  endtask

  task automatic test_random();
    int len;
    int idx;
    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(0, 15);
      idx = $urandom_range(0, DEPTH - 1);
      fill_wq(len + 1, 1'b0);
      do_write(32'(idx * 4), len, -1);
      checks++;
      if (got_bresp !== 2'b00) begin errors++; $display("FAIL rand_bresp %0d: got %0d, required 0", it, got_bresp); end
      check_read(32'(idx * 4), len, -1, "rand_readback");
      check_read(32'($urandom_range(0, DEPTH - 1) * 4), $urandom_range(0, 15), -1, "rand_read");
    end
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    test_reset();
    test_fill_max_burst();
    test_basic();
    test_strobe();
    test_wrap();
    test_out_of_range();
    test_wlast_early_and_hold();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
